// File: rtl/shiftreg_pkg.sv
// Shared definitions for the 4-bit mode-controlled shift register and its command sequencer.
// Mode encoding and sequencer state encoding.
package shiftreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ROR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFin  = 2'b10
  } state_e;

endpackage

// File: rtl/shiftreg_seq_if.sv
// Host-side command and status bundle of the shift-register sequencer.
interface shiftreg_seq_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_cnt;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, abort,
    input  cmd_ready, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, abort,
    output cmd_ready, busy, done, aborted
  );

endinterface

// File: rtl/shiftreg_seq_cnt.sv
// Repeat counter for the sequencer: loadable down-counter with terminal-count flag (rem==1)
// plus a step up-counter that restarts at zero on every load.
module shiftreg_seq_cnt #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_one,
  input  logic          i_en,
  input  logic [CW-1:0] i_cnt,
  output logic [CW-1:0] o_step,
  output logic          o_tc
);

  // rem is one bit wider so that a zero count can stand for 2**CW repeats
  localparam logic [CW:0] Full = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0] One  = {{CW{1'b0}}, 1'b1};

  logic [CW:0]   r_rem;
  logic [CW-1:0] r_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_step <= '0;
    end else if (i_load) begin
      r_rem  <= i_one ? One : ((i_cnt == '0) ? Full : {1'b0, i_cnt});
      r_step <= '0;
    end else if (i_en) begin
      r_rem  <= r_rem - One;
      r_step <= r_step + 1'b1;
    end
  end

  assign o_step = r_step;
  assign o_tc   = (r_rem == One);

endmodule

// File: rtl/shiftreg_seq.sv
// Command sequencer driving m/d/si of the mode-controlled shift register for N cycles per
// accepted command; all outputs are registered and computed from the next state.
module shiftreg_seq
  import shiftreg_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  shiftreg_seq_if.slave host,
  output logic [1:0]   m,
  output logic [W-1:0] d,
  output logic         si
);

  state_e        r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [W-1:0]  r_data;
  logic          r_abt;
  logic          r_ready, r_busy, r_done, r_aborted, r_si;
  logic [1:0]    r_m;
  logic [W-1:0]  r_d;

  logic          w_accept, w_fin, w_tc;
  logic [CW-1:0] w_step, w_step_nxt;
  logic [1:0]    w_op_act;
  logic [W-1:0]  w_data_act, w_sh;
  logic [1:0]    w_m_nxt;
  logic [W-1:0]  w_d_nxt;
  logic          w_si_nxt;

  shiftreg_seq_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_one  (host.cmd_op == MODE_LOAD),
    .i_en   (r_state == StRun),
    .i_cnt  (host.cmd_cnt),
    .o_step (w_step),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == StIdle) && r_ready && host.cmd_valid;
    // abort only ends a command early; on the final edge the command has completed anyway
    w_fin       = (r_state == StRun) && (w_tc || host.abort);
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StRun;
      StRun:   if (w_fin) w_state_nxt = StFin;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase

    w_op_act   = w_accept ? host.cmd_op : r_op;
    w_data_act = w_accept ? host.cmd_data : r_data;
    w_step_nxt = w_accept ? '0 : w_step + 1'b1;
    // SHL feeds data MSB-first, wrapping every W bits
    w_sh       = w_data_act << (w_step_nxt % W);

    w_m_nxt  = MODE_HOLD;
    w_d_nxt  = '0;
    w_si_nxt = 1'b0;
    if (w_state_nxt == StRun) begin
      w_m_nxt = w_op_act;
      if (w_op_act == MODE_LOAD) w_d_nxt = w_data_act;
      if (w_op_act == MODE_SHL) w_si_nxt = w_sh[W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_op      <= MODE_HOLD;
      r_data    <= '0;
      r_abt     <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_m       <= MODE_HOLD;
      r_d       <= '0;
      r_si      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= host.cmd_op;
        r_data <= host.cmd_data;
        r_abt  <= 1'b0;
      end else if (w_fin) begin
        r_abt <= host.abort && !w_tc;
      end
      r_ready   <= (w_state_nxt == StIdle);
      r_busy    <= (w_state_nxt == StRun);
      r_done    <= (r_state == StFin);
      r_aborted <= (r_state == StFin) && r_abt;
      r_m       <= w_m_nxt;
      r_d       <= w_d_nxt;
      r_si      <= w_si_nxt;
    end
  end

  assign host.cmd_ready = r_ready;
  assign host.busy      = r_busy;
  assign host.done      = r_done;
  assign host.aborted   = r_aborted;
  assign m              = r_m;
  assign d              = r_d;
  assign si             = r_si;

endmodule
